// File: rtl/serial_pattern_scanner_if.sv
// Word stream between an upstream source and the pattern scanner.
// The source drives valid/data/last and the scanner answers with ready.
interface serial_pattern_scanner_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/serial_pattern_scanner.sv
// Serialises upstream words MSB first into a programmable pattern detector
// and counts the matches of each start/done job.
module serial_pattern_scanner #(
  parameter int DW   = 8,
  parameter int PMAX = 8,
  parameter int CW   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [PMAX-1:0]            cfg_pattern,
  input  logic [$clog2(PMAX+1)-1:0]  cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       start,
  serial_pattern_scanner_if.slave    in_if,
  output logic                       busy,
  output logic                       match_pulse,
  output logic [CW-1:0]              match_count,
  output logic                       done,
  output logic                       err_cfg
);

  localparam int LW = $clog2(PMAX + 1);
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [LW-1:0] LEN_MAX = LW'(PMAX);
  localparam logic [LW-1:0] LEN_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_TOP = IW'(DW - 1);
  localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]      state_r,   state_s;
  logic [PMAX-1:0] pattern_r, pattern_s;
  logic [LW-1:0]   len_r,     len_s;
  logic            overlap_r, overlap_s;
  logic            cfg_ok_r,  cfg_ok_s;
  logic            err_cfg_r, err_cfg_s;
  logic [DW-1:0]   word_r,    word_s;
  logic            last_r,    last_s;
  logic [IW-1:0]   idx_r,     idx_s;
  logic [PMAX-1:0] hist_r,    hist_s;
  logic [LW-1:0]   bitcnt_r,  bitcnt_s;
  logic [CW-1:0]   count_r,   count_s;
  logic            match_s;
  logic            match_pulse_r;
  logic            done_r;
  logic            busy_r;
  logic            in_ready_r;

  logic [PMAX-1:0] hist_shift_s;
  logic [PMAX-1:0] mask_s;
  logic [LW-1:0]   cnt_inc_s;
  logic            hit_s;

  // Next-state, configuration and detector datapath
  always_comb begin
    state_s   = state_r;
    pattern_s = pattern_r;
    len_s     = len_r;
    overlap_s = overlap_r;
    cfg_ok_s  = cfg_ok_r;
    err_cfg_s = err_cfg_r;
    word_s    = word_r;
    last_s    = last_r;
    idx_s     = idx_r;
    hist_s    = hist_r;
    bitcnt_s  = bitcnt_r;
    count_s   = count_r;
    match_s   = 1'b0;

    // The match test looks at the history as it will be after this shift.
    hist_shift_s = {hist_r[PMAX-2:0], word_r[idx_r]};
    mask_s       = ~({PMAX{1'b1}} << len_r);
    cnt_inc_s    = (bitcnt_r < LEN_MAX) ? (bitcnt_r + LEN_ONE) : bitcnt_r;
    hit_s        = ((hist_shift_s & mask_s) == (pattern_r & mask_s)) && (cnt_inc_s >= len_r);

    case (state_r)
      ST_IDLE: begin
        if (cfg_we) begin
          if ((cfg_len == '0) || (cfg_len > LEN_MAX)) begin
            err_cfg_s = 1'b1;
          end else begin
            pattern_s = cfg_pattern;
            len_s     = cfg_len;
            overlap_s = cfg_overlap;
            cfg_ok_s  = 1'b1;
            err_cfg_s = 1'b0;
          end
        end else begin
          err_cfg_s = err_cfg_r;
        end
        if (start && !err_cfg_r && cfg_ok_r) begin
          state_s  = ST_WAIT;
          hist_s   = '0;
          bitcnt_s = '0;
          count_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (in_if.in_valid) begin
          word_s  = in_if.in_data;
          last_s  = in_if.in_last;
          idx_s   = IDX_TOP;
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SHIFT: begin
        hist_s = hist_shift_s;
        if (hit_s) begin
          match_s  = 1'b1;
          count_s  = (count_r != CNT_MAX) ? (count_r + CNT_ONE) : count_r;
          // Non-overlap mode demands a full pattern's worth of fresh bits.
          bitcnt_s = overlap_r ? cnt_inc_s : '0;
        end else begin
          bitcnt_s = cnt_inc_s;
        end
        if (idx_r == '0) begin
          state_s = last_r ? ST_DONE : ST_WAIT;
        end else begin
          idx_s   = idx_r - IDX_ONE;
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; flags follow the next state so they align with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pattern_r     <= '0;
      len_r         <= '0;
      overlap_r     <= 1'b0;
      cfg_ok_r      <= 1'b0;
      err_cfg_r     <= 1'b0;
      word_r        <= '0;
      last_r        <= 1'b0;
      idx_r         <= '0;
      hist_r        <= '0;
      bitcnt_r      <= '0;
      count_r       <= '0;
      match_pulse_r <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      in_ready_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      pattern_r     <= pattern_s;
      len_r         <= len_s;
      overlap_r     <= overlap_s;
      cfg_ok_r      <= cfg_ok_s;
      err_cfg_r     <= err_cfg_s;
      word_r        <= word_s;
      last_r        <= last_s;
      idx_r         <= idx_s;
      hist_r        <= hist_s;
      bitcnt_r      <= bitcnt_s;
      count_r       <= count_s;
      match_pulse_r <= match_s;
      done_r        <= (state_s == ST_DONE);
      busy_r        <= (state_s != ST_IDLE);
      in_ready_r    <= (state_s == ST_WAIT);
    end
  end

  assign in_if.in_ready = in_ready_r;
  assign busy           = busy_r;
  assign match_pulse    = match_pulse_r;
  assign match_count    = count_r;
  assign done           = done_r;
  assign err_cfg        = err_cfg_r;

endmodule

// File: tb/tb_serial_pattern_scanner.sv
// Randomised scoreboard bench for serial_pattern_scanner: a bit-stream model
// predicts match/done cycles at word acceptance, a monitor checks them.
module tb_serial_pattern_scanner;
  localparam int DW   = 8;
  localparam int PMAX = 8;
  localparam int CW   = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_we;
  logic [PMAX-1:0] cfg_pattern;
  logic [3:0]      cfg_len;
  logic            cfg_overlap;
  logic            start;
  logic            busy, match_pulse, done, err_cfg;
  logic [CW-1:0]   match_count;

  serial_pattern_scanner_if #(.DW(DW)) sif ();

  serial_pattern_scanner #(.DW(DW), .PMAX(PMAX), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .in_if(sif),
    .busy(busy), .match_pulse(match_pulse), .match_count(match_count),
    .done(done), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard queues: expected match cycles, done cycles and counts at done
  int mq[$];
  int dq[$];
  int dcq[$];
  int rdy_total = 0;
  logic exp_m, exp_d;

  always @(negedge clk) begin
    if (!reset) begin
      exp_m = (mq.size() > 0) && (mq[0] == cyc);
      if (exp_m || match_pulse) chk("match_pulse", match_pulse, exp_m);
      if (exp_m) void'(mq.pop_front());
      exp_d = (dq.size() > 0) && (dq[0] == cyc);
      if (exp_d || done) chk("done", done, exp_d);
      if (exp_d) begin
        chk("match_count_at_done", match_count, dcq[0]);
        void'(dq.pop_front());
        void'(dcq.pop_front());
      end
      if (sif.in_ready) rdy_total++;
    end
  end

  // reference model: stored config plus the job's bit stream
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ov;
  bit          m_err;
  int          m_since;
  logic [31:0] m_win;
  int          m_count;
  logic [7:0]  jw[0:7];
  int          jn;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_word(input logic [7:0] d, input bit l, input int c);
    logic [31:0] mask;
    mask = (32'd1 << m_len) - 32'd1;
    for (int b = 0; b < DW; b++) begin
      m_win = {m_win[30:0], d[DW-1-b]};
      m_since++;
      if (m_since >= m_len && (m_win & mask) == ({24'd0, m_pat} & mask)) begin
        mq.push_back(c + b + 1);
        if (m_count < 65535) m_count++;
        if (!m_ov) m_since = 0;
      end
    end
    if (l) begin
      dq.push_back(c + DW);
      dcq.push_back(m_count);
    end
  endtask

  task automatic cfg_write(input logic [7:0] pat, input int len, input bit ov, input bit idle);
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    cfg_overlap = ov;
    cfg_we      = 1'b1;
    tick();
    cfg_we = 1'b0;
    if (idle) begin
      if (len >= 1 && len <= PMAX) begin
        m_pat = pat; m_len = len; m_ov = ov; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    chk("err_cfg", err_cfg, m_err);
  endtask

  task automatic send_word(input logic [7:0] d, input bit l, input int gap, output int acc);
    int t;
    sif.in_valid = 1'b0;
    repeat (gap) tick();
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    sif.in_last  = l;
    t = 0;
    while (!sif.in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!sif.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      acc = cyc;
    end else begin
      acc = cyc + 1;
      model_word(d, l, acc);
      tick();
    end
    sif.in_valid = 1'b0;
  endtask

  task automatic run_job(input int gap, input int mid_mode, input int exp_cnt);
    int acc, prev, r0, t, g;
    m_since = 0; m_win = '0; m_count = 0;
    prev = 0;
    r0 = rdy_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("count_cleared_at_start", match_count, 0);
    for (int i = 0; i < jn; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      send_word(jw[i], (i == jn - 1), g, acc);
      if (gap == 0 && i > 0) chk("accept_spacing", acc - prev, DW + 1);
      prev = acc;
      if (i == 0 && mid_mode == 1) cfg_write(~m_pat, PMAX, ~m_ov, 1'b0);
      if (i == 0 && mid_mode == 2) cfg_write(8'h00, 0, 1'b0, 1'b0);
    end
    t = 0;
    while (dq.size() > 0 && t < 60) begin
      tick();
      t++;
    end
    chk("done_pending", dq.size(), 0);
    dq.delete();
    dcq.delete();
    tick();
    chk("busy_after_done", busy, 0);
    if (gap == 0) chk("ready_cycles", rdy_total - r0, jn);
    if (exp_cnt >= 0) chk("job_match_count", match_count, exp_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; sif.in_valid = 1'b0; sif.in_data = '0; sif.in_last = 1'b0;
    m_pat = '0; m_len = 0; m_ov = 1'b0; m_err = 1'b0;
    m_since = 0; m_win = '0; m_count = 0; jn = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", sif.in_ready, 0);
    chk("rst_match_pulse", match_pulse, 0);
    chk("rst_done", done, 0);
    chk("rst_match_count", match_count, 0);
    chk("rst_err_cfg", err_cfg, 0);
    reset = 1'b0;
    tick();

    // start without any legal config, then with an error latched
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("start_no_cfg_busy", busy, 0);
    cfg_write(8'h15, 0, 1'b1, 1'b1);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("start_err_busy", busy, 0);
    cfg_write(8'h15, 9, 1'b1, 1'b1);
    cfg_write(8'h15, 6, 1'b1, 1'b1);

    // directed single and double word jobs
    jn = 1; jw[0] = 8'h55;
    run_job(0, 0, 2);
    cfg_write(8'h15, 6, 1'b0, 1'b1);
    run_job(0, 0, 1);
    jn = 2; jw[1] = 8'h55;
    cfg_write(8'h15, 6, 1'b1, 1'b1);
    run_job(0, 0, 6);
    cfg_write(8'h15, 6, 1'b0, 1'b1);
    run_job(0, 0, 2);

    // backpressure with valid held continuously
    cfg_write(8'h05, 3, 1'b1, 1'b1);
    jn = 4;
    for (int i = 0; i < 4; i++) jw[i] = 8'($urandom);
    run_job(0, 0, -1);

    // config writes while busy must not take effect
    jn = 2; jw[0] = 8'($urandom); jw[1] = 8'($urandom);
    run_job(-1, 1, -1);
    run_job(-1, 2, -1);
    jw[0] = 8'($urandom); jw[1] = 8'($urandom);
    run_job(-1, 0, -1);

    // randomised configurations and streams
    for (int k = 0; k < 25; k++) begin
      cfg_write(8'($urandom), int'($urandom_range(1, PMAX)), 1'($urandom), 1'b1);
      jn = int'($urandom_range(1, 4));
      for (int i = 0; i < jn; i++) jw[i] = 8'($urandom);
      run_job(-1, 0, -1);
    end

    // reset in the middle of a word
    cfg_write(8'h0b, 4, 1'b1, 1'b1);
    m_since = 0; m_win = '0; m_count = 0;
    start = 1'b1; tick(); start = 1'b0;
    send_word(8'hb0, 1'b0, 0, acc);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", sif.in_ready, 0);
    chk("midrst_match_pulse", match_pulse, 0);
    chk("midrst_done", done, 0);
    chk("midrst_match_count", match_count, 0);
    chk("midrst_err_cfg", err_cfg, 0);
    mq.delete(); dq.delete(); dcq.delete();
    m_err = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("postrst_start_no_cfg", busy, 0);
    cfg_write(8'h0b, 4, 1'b1, 1'b1);
    jn = 2; jw[0] = 8'h00; jw[1] = 8'hb0;
    run_job(0, 0, 1);

    tick();
    chk("scoreboard_empty", mq.size() + dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
